vga_timing_fsm: RTL and testbench

VGA raster timing generator. It produces hsync/vsync and gates RGB pixel data from an upstream pixel stream according to programmable horizontal and vertical timing. It sits between the framebuffer fetcher, which supplies pixels over a valid/ready handshake, and the VGA pins. It advances one pixel per cycle in which the external pixel-clock enable is asserted.

---
 rtl/vga_timing_fsm.sv | 163 ++++++++++++++++
 tb/tb_vga_timing_fsm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_fsm.sv
// rtl/vga_timing_fsm.sv - VGA raster timing generator gating a pixel stream; optional VGA_TIMING_UNDERFLOW_CNT_EN adds an underflow counter
module vga_timing_fsm #(
    parameter int RedWidth    = 5,
    parameter int GreenWidth  = 6,
    parameter int BlueWidth   = 5,
    parameter int HCountWidth = 32,
    parameter int VCountWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   fsm_en_i,
    input  logic                   enable_i,
    input  logic                   hsync_pol_i,
    input  logic                   vsync_pol_i,
    input  logic [HCountWidth-1:0] h_visible_i,
    input  logic [HCountWidth-1:0] h_front_i,
    input  logic [HCountWidth-1:0] h_sync_i,
    input  logic [HCountWidth-1:0] h_back_i,
    input  logic [VCountWidth-1:0] v_visible_i,
    input  logic [VCountWidth-1:0] v_front_i,
    input  logic [VCountWidth-1:0] v_sync_i,
    input  logic [VCountWidth-1:0] v_back_i,
    input  logic [RedWidth-1:0]    red_i,
    input  logic [GreenWidth-1:0]  green_i,
    input  logic [BlueWidth-1:0]   blue_i,
    input  logic                   valid_i,
`ifdef VGA_TIMING_UNDERFLOW_CNT_EN
    output logic [15:0]            underflow_cnt_o,
`endif
    output logic                   ready_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic [RedWidth-1:0]    red_o,
    output logic [GreenWidth-1:0]  green_o,
    output logic [BlueWidth-1:0]   blue_o
);

    typedef enum logic [1:0] {S_VISIBLE, S_FRONT, S_SYNC, S_BACK} region_e;

    localparam logic [HCountWidth-1:0] HOne = 1;
    localparam logic [VCountWidth-1:0] VOne = 1;

    logic [HCountWidth-1:0] h_cnt_q, h_cnt_d, h_b1, h_b2, h_b3, h_tot;
    logic [VCountWidth-1:0] v_cnt_q, v_cnt_d, v_b1, v_b2, v_b3, v_tot;
    logic [RedWidth-1:0]    red_q, red_d;
    logic [GreenWidth-1:0]  green_q, green_d;
    logic [BlueWidth-1:0]   blue_q, blue_d;
    logic                   hsync_q, hsync_d, vsync_q, vsync_d;
    region_e                h_region, v_region;
    logic                   advance, active, in_hsync, in_vsync;

    // Cumulative region boundaries, truncated to counter width
    assign h_b1  = h_visible_i;
    assign h_b2  = h_b1 + h_front_i;
    assign h_b3  = h_b2 + h_sync_i;
    assign h_tot = h_b3 + h_back_i;
    assign v_b1  = v_visible_i;
    assign v_b2  = v_b1 + v_front_i;
    assign v_b3  = v_b2 + v_sync_i;
    assign v_tot = v_b3 + v_back_i;

    // Decode current region from counters; zero-length regions fall through
    always_comb begin
        h_region = S_BACK;
        if (h_cnt_q < h_b1)      h_region = S_VISIBLE;
        else if (h_cnt_q < h_b2) h_region = S_FRONT;
        else if (h_cnt_q < h_b3) h_region = S_SYNC;
        v_region = S_BACK;
        if (v_cnt_q < v_b1)      v_region = S_VISIBLE;
        else if (v_cnt_q < v_b2) v_region = S_FRONT;
        else if (v_cnt_q < v_b3) v_region = S_SYNC;
    end

    assign advance  = enable_i && fsm_en_i;
    assign active   = (h_region == S_VISIBLE) && (v_region == S_VISIBLE);
    assign in_hsync = (h_tot != '0) && (h_region == S_SYNC);
    assign in_vsync = (v_tot != '0) && (v_region == S_SYNC);
    assign ready_o  = advance && active;

    // Next counters and registered pins; everything holds between advancing cycles
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (!enable_i) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
            hsync_d = ~hsync_pol_i;
            vsync_d = ~vsync_pol_i;
        end else if (fsm_en_i) begin
            // An underflowed slot is shown black and never retried
            red_d   = (active && valid_i) ? red_i   : '0;
            green_d = (active && valid_i) ? green_i : '0;
            blue_d  = (active && valid_i) ? blue_i  : '0;
            hsync_d = in_hsync ? hsync_pol_i : ~hsync_pol_i;
            vsync_d = in_vsync ? vsync_pol_i : ~vsync_pol_i;
            if (h_tot == '0) begin
                h_cnt_d = '0;
            end else if (h_cnt_q >= h_tot - HOne) begin
                // >= so a counter stranded past a shrunken total recovers
                h_cnt_d = '0;
                if (v_tot == '0 || v_cnt_q >= v_tot - VOne) v_cnt_d = '0;
                else                                        v_cnt_d = v_cnt_q + VOne;
            end else begin
                h_cnt_d = h_cnt_q + HOne;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign red_o   = red_q;
    assign green_o = green_q;
    assign blue_o  = blue_q;

`ifdef VGA_TIMING_UNDERFLOW_CNT_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;

    // Saturating count of active slots with no pixel available
    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (!enable_i) uf_cnt_d = '0;
        else if (advance && active && !valid_i && uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
    end

    // Underflow counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) uf_cnt_q <= '0;
        else       uf_cnt_q <= uf_cnt_d;
    end

    assign underflow_cnt_o = uf_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_fsm.sv
// tb/tb_vga_timing_fsm.sv - directed self-checking bench for vga_timing_fsm
module tb_vga_timing_fsm;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        fsm_en_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        hsync_pol_i = 1'b1;
    logic        vsync_pol_i = 1'b1;
    logic [31:0] h_visible_i = 32'd4, h_front_i = 32'd1, h_sync_i = 32'd2, h_back_i = 32'd1;
    logic [31:0] v_visible_i = 32'd2, v_front_i = 32'd1, v_sync_i = 32'd1, v_back_i = 32'd1;
    logic [4:0]  red_i = '0;
    logic [5:0]  green_i = '0;
    logic [4:0]  blue_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o, hsync_o, vsync_o;
    logic [4:0]  red_o;
    logic [5:0]  green_o;
    logic [4:0]  blue_o;
    logic [15:0] underflow_cnt_o;

    vga_timing_fsm dut (
        .clk_i(clk_i), .rst_i(rst_i), .fsm_en_i(fsm_en_i), .enable_i(enable_i),
        .hsync_pol_i(hsync_pol_i), .vsync_pol_i(vsync_pol_i),
        .h_visible_i(h_visible_i), .h_front_i(h_front_i), .h_sync_i(h_sync_i), .h_back_i(h_back_i),
        .v_visible_i(v_visible_i), .v_front_i(v_front_i), .v_sync_i(v_sync_i), .v_back_i(v_back_i),
        .red_i(red_i), .green_i(green_i), .blue_i(blue_i), .valid_i(valid_i),
`ifdef VGA_TIMING_UNDERFLOW_CNT_EN
        .underflow_cnt_o(underflow_cnt_o),
`endif
        .ready_o(ready_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o)
    );

`ifndef VGA_TIMING_UNDERFLOW_CNT_EN
    assign underflow_cnt_o = '0;
`endif

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int eh = 0, ev = 0, d = 0;
    logic [4:0] exp_r = '0, exp_b = '0;
    logic [5:0] exp_g = '0;
    logic       exp_hs = 1'b0, exp_vs = 1'b0;
    int         exp_uf = 0;

    function automatic void set_pixel();
        red_i   = 5'(d);
        green_i = 6'(d * 3);
        blue_i  = ~5'(d);
    endfunction

    function automatic bit exp_ready();
        return enable_i && fsm_en_i && (eh < int'(h_visible_i)) && (ev < int'(v_visible_i));
    endfunction

    // Reference model of one clock edge, evaluated on the pre-edge inputs
    function automatic void model_edge();
        int hv, hf, hs, htot, vv, vf, vs, vtot;
        bit act;
        hv = int'(h_visible_i); hf = int'(h_front_i); hs = int'(h_sync_i);
        htot = hv + hf + hs + int'(h_back_i);
        vv = int'(v_visible_i); vf = int'(v_front_i); vs = int'(v_sync_i);
        vtot = vv + vf + vs + int'(v_back_i);
        if (!enable_i) begin
            eh = 0; ev = 0; exp_uf = 0;
            exp_r = '0; exp_g = '0; exp_b = '0;
            exp_hs = !hsync_pol_i; exp_vs = !vsync_pol_i;
        end else if (fsm_en_i) begin
            act = (eh < hv) && (ev < vv);
            exp_r = (act && valid_i) ? red_i : '0;
            exp_g = (act && valid_i) ? green_i : '0;
            exp_b = (act && valid_i) ? blue_i : '0;
            if (act && !valid_i && exp_uf < 65535) exp_uf++;
            exp_hs = (htot != 0 && eh >= hv + hf && eh < hv + hf + hs) ? hsync_pol_i : !hsync_pol_i;
            exp_vs = (vtot != 0 && ev >= vv + vf && ev < vv + vf + vs) ? vsync_pol_i : !vsync_pol_i;
            if (htot == 0) eh = 0;
            else if (eh >= htot - 1) begin
                eh = 0;
                if (vtot == 0 || ev >= vtot - 1) ev = 0; else ev++;
            end else eh++;
        end
    endfunction

    task automatic step();
        bit acc;
        acc = exp_ready() && valid_i;
        @(posedge clk_i);
        model_edge();
        if (acc) d++;
        #1;
    endtask

    task automatic restart();
        enable_i = 1'b0; fsm_en_i = 1'b1; valid_i = 1'b0;
        #1; step();
        enable_i = 1'b1;
    endtask

    task automatic test_reset();
        enable_i = 1'b0;
        #1 rst_i = 1'b1;
        #2;
        checks++; if ({hsync_o, vsync_o} !== 2'b00) begin errors++; $display("FAIL reset_sync got %b exp 00", {hsync_o, vsync_o}); end
        checks++; if ({red_o, green_o, blue_o} !== 16'h0) begin errors++; $display("FAIL reset_rgb got %h exp 0", {red_o, green_o, blue_o}); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready_o); end
        #1 rst_i = 1'b0;
        hsync_pol_i = 1'b0; vsync_pol_i = 1'b0;
        step();
        checks++; if ({hsync_o, vsync_o} !== 2'b11) begin errors++; $display("FAIL idle_pol0_sync got %b exp 11", {hsync_o, vsync_o}); end
        hsync_pol_i = 1'b1; vsync_pol_i = 1'b1;
        step();
        checks++; if ({hsync_o, vsync_o} !== 2'b00) begin errors++; $display("FAIL idle_pol1_sync got %b exp 00", {hsync_o, vsync_o}); end
    endtask

    task automatic test_free_run();
        int rdy_n = 0, hs_n = 0, vs_n = 0;
        restart();
        for (int i = 0; i < 80; i++) begin
            valid_i = 1'b1; set_pixel();
            #1;
            checks++; if (ready_o !== exp_ready()) begin errors++; $display("FAIL free_ready h=%0d v=%0d got %b exp %b", eh, ev, ready_o, exp_ready()); end
            if (i < 40 && ready_o === 1'b1) rdy_n++;
            step();
            checks++; if ({red_o, green_o, blue_o} !== {exp_r, exp_g, exp_b}) begin errors++; $display("FAIL free_rgb i=%0d got %h exp %h", i, {red_o, green_o, blue_o}, {exp_r, exp_g, exp_b}); end
            checks++; if ({hsync_o, vsync_o} !== {exp_hs, exp_vs}) begin errors++; $display("FAIL free_sync i=%0d got %b exp %b", i, {hsync_o, vsync_o}, {exp_hs, exp_vs}); end
            if (i < 40) begin hs_n += int'(hsync_o); vs_n += int'(vsync_o); end
        end
        checks++; if (rdy_n != 8) begin errors++; $display("FAIL free_ready_count got %0d exp 8", rdy_n); end
        checks++; if (hs_n != 10) begin errors++; $display("FAIL free_hsync_count got %0d exp 10", hs_n); end
        checks++; if (vs_n != 8) begin errors++; $display("FAIL free_vsync_count got %0d exp 8", vs_n); end
    endtask

    task automatic test_underflow();
        restart();
        for (int i = 0; i < 8; i++) begin
            valid_i = !(eh == 2 && ev == 0); set_pixel();
            #1;
            checks++; if (ready_o !== exp_ready()) begin errors++; $display("FAIL uf_ready h=%0d got %b exp %b", eh, ready_o, exp_ready()); end
            step();
            checks++; if ({red_o, green_o, blue_o} !== {exp_r, exp_g, exp_b}) begin errors++; $display("FAIL uf_rgb i=%0d got %h exp %h", i, {red_o, green_o, blue_o}, {exp_r, exp_g, exp_b}); end
            if (i == 2) begin
                checks++; if ({red_o, green_o, blue_o} !== 16'h0) begin errors++; $display("FAIL uf_slot_black got %h exp 0", {red_o, green_o, blue_o}); end
            end
`ifdef VGA_TIMING_UNDERFLOW_CNT_EN
            checks++; if (int'(underflow_cnt_o) != exp_uf) begin errors++; $display("FAIL uf_count i=%0d got %0d exp %0d", i, underflow_cnt_o, exp_uf); end
`endif
        end
`ifdef VGA_TIMING_UNDERFLOW_CNT_EN
        checks++; if (underflow_cnt_o !== 16'd1) begin errors++; $display("FAIL uf_count_final got %0d exp 1", underflow_cnt_o); end
`endif
    endtask

    task automatic test_clock_enable();
        int rdy_n = 0;
        restart();
        for (int i = 0; i < 48; i++) begin
            valid_i = 1'b1; fsm_en_i = (i % 3 == 0); set_pixel();
            #1;
            checks++; if (ready_o !== exp_ready()) begin errors++; $display("FAIL ce_ready i=%0d got %b exp %b", i, ready_o, exp_ready()); end
            if (ready_o === 1'b1) rdy_n++;
            step();
            checks++; if ({red_o, green_o, blue_o, hsync_o, vsync_o} !== {exp_r, exp_g, exp_b, exp_hs, exp_vs}) begin
                errors++; $display("FAIL ce_out i=%0d got %h exp %h", i, {red_o, green_o, blue_o, hsync_o, vsync_o}, {exp_r, exp_g, exp_b, exp_hs, exp_vs});
            end
        end
        fsm_en_i = 1'b1;
        checks++; if (rdy_n != 8) begin errors++; $display("FAIL ce_ready_count got %0d exp 8", rdy_n); end
    endtask

    task automatic test_mid_frame_disable();
        restart();
        valid_i = 1'b1;
        for (int i = 0; i < 13; i++) begin set_pixel(); step(); end
        checks++; if (!(eh == 5 && ev == 1)) begin errors++; $display("FAIL mid_position got h=%0d v=%0d exp h=5 v=1", eh, ev); end
        enable_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL mid_ready_off got %b exp 0", ready_o); end
        step();
        checks++; if ({red_o, green_o, blue_o, hsync_o, vsync_o} !== 18'h0) begin errors++; $display("FAIL mid_idle_out got %h exp 0", {red_o, green_o, blue_o, hsync_o, vsync_o}); end
        enable_i = 1'b1; set_pixel();
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mid_first_ready got %b exp 1", ready_o); end
        step();
        checks++; if ({red_o, green_o, blue_o} !== {exp_r, exp_g, exp_b}) begin errors++; $display("FAIL mid_first_pixel got %h exp %h", {red_o, green_o, blue_o}, {exp_r, exp_g, exp_b}); end
    endtask

    task automatic test_shrink_total();
        int rdy_n = 0;
        restart();
        valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin set_pixel(); step(); end
        h_visible_i = 32'd2;
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL shrink_ready_at6 got %b exp 0", ready_o); end
        step();
        checks++; if (!(eh == 0 && ev == 1)) begin errors++; $display("FAIL shrink_wrap model h=%0d v=%0d", eh, ev); end
        for (int i = 0; i < 12; i++) begin
            set_pixel();
            #1;
            checks++; if (ready_o !== exp_ready()) begin errors++; $display("FAIL shrink_ready i=%0d got %b exp %b", i, ready_o, exp_ready()); end
            if (ready_o === 1'b1) rdy_n++;
            step();
            checks++; if ({red_o, green_o, blue_o, hsync_o, vsync_o} !== {exp_r, exp_g, exp_b, exp_hs, exp_vs}) begin
                errors++; $display("FAIL shrink_out i=%0d got %h exp %h", i, {red_o, green_o, blue_o, hsync_o, vsync_o}, {exp_r, exp_g, exp_b, exp_hs, exp_vs});
            end
        end
        checks++; if (rdy_n != 2) begin errors++; $display("FAIL shrink_ready_count got %0d exp 2", rdy_n); end
        h_visible_i = 32'd4;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_underflow();
        test_clock_enable();
        test_mid_frame_disable();
        test_shrink_total();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
